hazard_fwd_ctrl: RTL and testbench

- Pipeline hazard controller for the 5-stage CPU.
- Resolves the ID-stage destination register (rt/rd select, same 0→rt, 1→rd convention as the register-destination mux). Tracks the destination register of the in-flight instruction in each of EX, MEM and WB.
- Drives the load-use stall and the two ALU operand forwarding mux selects. Sits beside the ID/EX, EX/MEM and MEM/WB pipeline registers.

---
 rtl/hazard_pkg.sv | 21 ++
 rtl/hazard_stage_slot.sv | 15 +
 rtl/hazard_fwd_ctrl.sv | 58 +++++
 tb/tb_hazard_fwd_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared slot type, forwarding encodings and match helpers for the hazard controller
package hazard_pkg;
  localparam int REG_ADDR_W_DEF = 5;
  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB = 2'b10;
  typedef struct packed {
    logic valid;
    logic we;
    logic mem_read;
    logic [REG_ADDR_W_DEF-1:0] dst;
    logic [REG_ADDR_W_DEF-1:0] rs;
    logic [REG_ADDR_W_DEF-1:0] rt;
  } stage_slot_t;
  function automatic logic slot_writes(stage_slot_t s, logic [REG_ADDR_W_DEF-1:0] r);
    return s.valid && s.we && s.dst != '0 && s.dst == r;
  endfunction
  function automatic logic [1:0] fwd_sel(stage_slot_t mem, stage_slot_t wb, logic [REG_ADDR_W_DEF-1:0] r);
    return slot_writes(mem, r) ? FWD_MEM : slot_writes(wb, r) ? FWD_WB : FWD_REGFILE;
  endfunction
endpackage

// File: rtl/hazard_stage_slot.sv
// hazard_stage_slot: one pipeline-stage tracking register; bubble loads an all-zero slot
module hazard_stage_slot
  import hazard_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        bubble,
  input  stage_slot_t d,
  output stage_slot_t q
);
  stage_slot_t slot_d, slot_q;
  always_comb slot_d = bubble ? '0 : d;
  always_ff @(posedge clk) slot_q <= rst ? '0 : slot_d;
  assign q = slot_q;
endmodule

// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: load-use stall and EX operand forwarding for the 5-stage pipe
// Optional saturating stall counter enabled by STALL_CNT_EN.
module hazard_fwd_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
`ifdef STALL_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_dst,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  output logic                  stall,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic [REG_ADDR_W-1:0] ex_dst,
  output logic [REG_ADDR_W-1:0] mem_dst,
  output logic [REG_ADDR_W-1:0] wb_dst,
  output logic                  wb_we
`ifdef STALL_CNT_EN
  , output logic [CNT_W-1:0]    stall_cnt
`endif
);
  stage_slot_t id_slot, ex_q, mem_q, wb_q;
  logic ex_bubble;
  always_comb begin
    id_slot = '{valid: 1'b1, we: id_reg_write, mem_read: id_mem_read,
                dst: id_reg_dst ? id_rd : id_rt, rs: id_rs, rt: id_rt};
    stall = id_valid && !flush && ex_q.valid && ex_q.mem_read && ex_q.we && ex_q.dst != '0 &&
            (ex_q.dst == id_rs || ex_q.dst == id_rt);
    ex_bubble = stall || flush || !id_valid;
  end
  hazard_stage_slot u_ex  (.clk(clk), .rst(rst), .bubble(ex_bubble), .d(id_slot), .q(ex_q));
  hazard_stage_slot u_mem (.clk(clk), .rst(rst), .bubble(1'b0),      .d(ex_q),    .q(mem_q));
  hazard_stage_slot u_wb  (.clk(clk), .rst(rst), .bubble(1'b0),      .d(mem_q),   .q(wb_q));
  always_comb begin
    fwd_a = fwd_sel(mem_q, wb_q, ex_q.rs);
    fwd_b = fwd_sel(mem_q, wb_q, ex_q.rt);
    ex_dst = ex_q.valid ? ex_q.dst : '0;
    mem_dst = mem_q.valid ? mem_q.dst : '0;
    wb_dst = wb_q.dst;
    wb_we = wb_q.valid && wb_q.we;
  end
`ifdef STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
  always_comb stall_cnt_d = (stall && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
  always_ff @(posedge clk) stall_cnt_q <= rst ? '0 : stall_cnt_d;
  assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// tb_hazard_fwd_ctrl: scoreboard bench comparing the hazard controller against an instruction-history model
module tb_hazard_fwd_ctrl;
  logic clk = 1'b1;
  logic rst, flush, id_valid, id_reg_dst, id_reg_write, id_mem_read;
  logic [4:0] id_rs, id_rt, id_rd;
  logic stall, wb_we;
  logic [1:0] fwd_a, fwd_b;
  logic [4:0] ex_dst, mem_dst, wb_dst;
`ifdef STALL_CNT_EN
  localparam int CNT_MAX = 3;
  logic [1:0] stall_cnt;
`endif
  typedef struct {bit v, we, mr; bit [4:0] dst, rs, rt;} rec_t;
  typedef struct {bit stall; bit [1:0] fa, fb; bit [4:0] exd, memd, wbd; bit wbwe; int cnt;} exp_t;
  rec_t hist[$];
  exp_t sb[$];
  bit ready = 0, last_stall = 0;
  int cnt_m = 0, tests = 0, fails = 0;

  hazard_fwd_ctrl #(.REG_ADDR_W(5)
`ifdef STALL_CNT_EN
    , .CNT_W(2)
`endif
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b), .ex_dst(ex_dst), .mem_dst(mem_dst),
    .wb_dst(wb_dst), .wb_we(wb_we)
`ifdef STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // hist holds what entered EX on each of the last three edges, oldest first
  function automatic bit [1:0] fwd_of(bit [4:0] src);
    for (int age = 1; age <= 2; age++) begin
      rec_t e = hist[2-age];
      if (e.v && e.we && e.dst != 0 && e.dst == src) return age == 1 ? 2'b01 : 2'b10;
    end
    return 2'b00;
  endfunction

  task automatic step(bit r, bit f, bit v, bit [4:0] rs, bit [4:0] rt, bit [4:0] rd, bit rdst, bit rw, bit mr);
    exp_t x;
    rec_t e, z;
    bit [4:0] dst;
    z = '{default: 0};
    x = '{default: 0};
    rst = r; flush = f; id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
    id_reg_dst = rdst; id_reg_write = rw; id_mem_read = mr;
    dst = rdst ? rd : rt;
    if (ready) begin
      e = hist[2];
      x.stall = v && !f && e.v && e.mr && e.we && e.dst != 0 && (e.dst == rs || e.dst == rt);
      x.fa = fwd_of(e.rs);
      x.fb = fwd_of(e.rt);
      x.exd = e.v ? e.dst : 0;
      x.memd = hist[1].v ? hist[1].dst : 0;
      x.wbd = hist[0].dst;
      x.wbwe = hist[0].v && hist[0].we;
      x.cnt = cnt_m;
      sb.push_back(x);
    end
    last_stall = x.stall;
    @(posedge clk);
    if (r) begin
      hist = {z, z, z};
      ready = 1;
      cnt_m = 0;
    end else if (ready) begin
      hist.push_back((x.stall || f || !v) ? z : '{1'b1, rw, mr, dst, rs, rt});
      void'(hist.pop_front());
`ifdef STALL_CNT_EN
      if (x.stall && cnt_m < CNT_MAX) cnt_m++;
`endif
    end
    #1;
  endtask

  task automatic nop(int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s at %0t: got %0d expected %0d", n, $time, a, e);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t x;
    if (sb.size() != 0) begin
      x = sb.pop_front();
      chk("stall", {31'd0, stall}, {31'd0, x.stall});
      chk("fwd_a", {30'd0, fwd_a}, {30'd0, x.fa});
      chk("fwd_b", {30'd0, fwd_b}, {30'd0, x.fb});
      chk("ex_dst", {27'd0, ex_dst}, {27'd0, x.exd});
      chk("mem_dst", {27'd0, mem_dst}, {27'd0, x.memd});
      chk("wb_dst", {27'd0, wb_dst}, {27'd0, x.wbd});
      chk("wb_we", {31'd0, wb_we}, {31'd0, x.wbwe});
`ifdef STALL_CNT_EN
      chk("stall_cnt", {30'd0, stall_cnt}, x.cnt);
`endif
    end
  end

  initial begin
    bit f, v, rdst, rw, mr;
    bit [4:0] rs, rt, rd;
    repeat (2) step(1, 1'($urandom), 1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                    1'($urandom), 1'($urandom), 1'($urandom));
    step(0, 0, 1, 1, 8, 0, 0, 1, 1);
    step(0, 0, 1, 8, 2, 9, 1, 1, 0);
    step(0, 0, 1, 8, 2, 9, 1, 1, 0);
    nop(3);
    step(0, 0, 1, 1, 2, 5, 1, 1, 0);
    step(0, 0, 1, 5, 5, 6, 1, 1, 0);
    nop(3);
    step(0, 0, 1, 1, 2, 3, 1, 1, 0);
    step(0, 0, 1, 4, 2, 3, 1, 1, 0);
    step(0, 0, 1, 3, 6, 7, 1, 1, 0);
    nop(3);
    step(0, 0, 1, 1, 0, 0, 0, 1, 1);
    step(0, 0, 1, 0, 0, 4, 1, 1, 0);
    nop(3);
    step(0, 0, 1, 1, 8, 0, 0, 1, 1);
    step(0, 1, 1, 8, 2, 9, 1, 1, 0);
    nop(4);
    step(0, 0, 1, 1, 7, 0, 0, 1, 1);
    step(0, 0, 1, 7, 7, 9, 1, 1, 0);
    step(0, 0, 1, 7, 7, 9, 1, 1, 0);
    nop(3);
    repeat (5) begin
      step(0, 0, 1, 1, 8, 0, 0, 1, 1);
      step(0, 0, 1, 8, 2, 9, 1, 1, 0);
      step(0, 0, 1, 8, 2, 9, 1, 1, 0);
    end
    nop(3);
    step(0, 0, 1, 1, 8, 0, 0, 1, 1);
    step(1, 0, 1, 8, 2, 9, 1, 1, 0);
    step(0, 0, 1, 8, 2, 9, 1, 1, 0);
    nop(3);
    {f, v, rdst, rw, mr, rs, rt, rd} = '0;
    for (int i = 0; i < 600; i++) begin
      if (!last_stall) begin
        f = ($urandom % 8) == 0;
        v = ($urandom % 5) != 0;
        rs = 5'($urandom % 6);
        rt = 5'($urandom % 6);
        rd = 5'($urandom % 6);
        rdst = 1'($urandom);
        rw = ($urandom % 4) != 0;
        mr = ($urandom % 3) == 0;
      end
      step(($urandom % 64) == 0, f, v, rs, rt, rd, rdst, rw, mr);
    end
    nop(2);
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
